// File: rtl/riscv_mem_pkg.sv
// riscv_mem_pkg: load funct3 codes, assembler FSM encoding and lane-select constants
package riscv_mem_pkg;
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam int HALF_SEL_BIT = 1;
   localparam logic [2:0] BYTE_LANE_LSBS = 3'b000;
   typedef enum logic [1:0] {S_IDLE, S_WAIT_HI, S_WAIT_LO, S_DONE} state_t;
   function automatic logic f3_legal(input logic [2:0] f3);
      return f3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
   endfunction
endpackage

// File: rtl/load_extend.sv
// load_extend: selects the byte/halfword/word of a load and sign- or zero-extends it
module load_extend
   import riscv_mem_pkg::*;
(
   input  logic [31:0] word,
   input  logic [2:0]  funct3,
   input  logic [1:0]  byte_off,
   output logic [31:0] rdata
);
   logic [7:0]  b;
   logic [15:0] h;
   assign b = word[{byte_off, BYTE_LANE_LSBS} +: 8];
   assign h = byte_off[HALF_SEL_BIT] ? word[31:16] : word[15:0];
   // extension by load type; illegal codes return zero
   always_comb begin
      rdata = funct3 == F3_LB  ? {{24{b[7]}}, b}  :
              funct3 == F3_LBU ? {24'd0, b}       :
              funct3 == F3_LH  ? {{16{h[15]}}, h} :
              funct3 == F3_LHU ? {16'd0, h}       :
              funct3 == F3_LW  ? word             : 32'd0;
   end
endmodule

// File: rtl/load_data_assembler.sv
// load_data_assembler: assembles two RAM halfwords into an extended load result (MISALIGN_TRAP_EN traps misaligned LH/LHU/LW)
module load_data_assembler
   import riscv_mem_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [2:0]  funct3,
   input  logic [1:0]  byte_off,
   input  logic [15:0] ram_data,
   input  logic        ram_valid,
   output logic        busy,
   output logic        done,
   output logic [31:0] rdata,
   output logic        err
);
   state_t      state;
   logic [2:0]  f3_q;
   logic [1:0]  off_q;
   logic [15:0] word_hi;
   logic [7:0]  cnt;
   logic [31:0] ext;
   logic        trap;
   logic        tmo;
   load_extend u_ext (
      .word     ({word_hi, ram_data}),
      .funct3   (f3_q),
      .byte_off (off_q),
      .rdata    (ext)
   );
   assign tmo = !ram_valid && cnt == 8'(TIMEOUT_CYCLES - 1);
`ifdef MISALIGN_TRAP_EN
   assign trap = !f3_legal(funct3) ||
                 ((funct3 == F3_LH || funct3 == F3_LHU) && byte_off[0]) ||
                 (funct3 == F3_LW && byte_off != 2'd0);
`else
   assign trap = !f3_legal(funct3);
`endif
   // load sequencing: capture halves, watch the timeout, register the result and pulses
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         err     <= 1'b0;
         rdata   <= 32'd0;
         word_hi <= 16'd0;
         cnt     <= 8'd0;
         f3_q    <= 3'd0;
         off_q   <= 2'd0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         cnt  <= 8'd0;
         case (state)
            S_IDLE: if (start) begin
               f3_q  <= funct3;
               off_q <= byte_off;
               if (trap) begin
                  state <= S_DONE;
                  done  <= 1'b1;
                  err   <= 1'b1;
                  rdata <= 32'd0;
               end else begin
                  state <= S_WAIT_HI;
                  busy  <= 1'b1;
               end
            end
            S_WAIT_HI: if (ram_valid) begin
               word_hi <= ram_data;
               state   <= S_WAIT_LO;
            end else if (tmo) begin
               state <= S_DONE;
               busy  <= 1'b0;
               done  <= 1'b1;
               err   <= 1'b1;
               rdata <= 32'd0;
            end else cnt <= cnt + 8'd1;
            S_WAIT_LO: if (ram_valid) begin
               state <= S_DONE;
               busy  <= 1'b0;
               done  <= 1'b1;
               rdata <= ext;
            end else if (tmo) begin
               state <= S_DONE;
               busy  <= 1'b0;
               done  <= 1'b1;
               err   <= 1'b1;
               rdata <= 32'd0;
            end else cnt <= cnt + 8'd1;
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_load_data_assembler.sv
// tb_load_data_assembler: table-driven, directed and randomized checks of load_data_assembler
module tb_load_data_assembler;
   localparam int T = 4;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  funct3 = 3'd0;
   logic [1:0]  byte_off = 2'd0;
   logic [15:0] ram_data = 16'd0;
   logic        ram_valid = 1'b0;
   logic        busy, done, err;
   logic [31:0] rdata;
   int checks = 0;
   int failures = 0;

   load_data_assembler #(.TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3), .byte_off(byte_off),
      .ram_data(ram_data), .ram_valid(ram_valid), .busy(busy), .done(done),
      .rdata(rdata), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  f3;
      logic [1:0]  off;
      logic [15:0] hi;
      logic [15:0] lo;
      int          g1;
      int          g2;
      logic [31:0] exp_rd;
      logic        exp_err;
      int          exp_lat;
   } vec_t;
   vec_t vecs[12];

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   function automatic logic legal(input logic [2:0] f3);
      return f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5;
   endfunction

   function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
`ifdef MISALIGN_TRAP_EN
      return ((f3 == 3'd1 || f3 == 3'd5) && off % 2 == 1) || (f3 == 3'd2 && off != 0);
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [31:0] model_ext(input logic [31:0] w, input logic [2:0] f3, input logic [1:0] off);
      int unsigned bt, hf;
      bt = (w / (32'd1 << (8 * int'(off)))) % 256;
      hf = off >= 2 ? w / 65536 : w % 65536;
      case (f3)
         3'd0: return 32'(bt) - (bt >= 128 ? 32'd256 : 32'd0);
         3'd4: return 32'(bt);
         3'd1: return 32'(hf) - (hf >= 32768 ? 32'd65536 : 32'd0);
         3'd5: return 32'(hf);
         3'd2: return w;
         default: return 32'd0;
      endcase
   endfunction

   task automatic do_load(input logic [2:0] f3, input logic [1:0] off, input logic [15:0] hi,
                          input logic [15:0] lo, input int g1, input int g2, input logic noise,
                          output int lat, output logic [31:0] rd, output logic er, output logic b1);
      int c;
      start = 1'b1; funct3 = f3; byte_off = off;
      c = 0; lat = -1; rd = 32'hx; er = 1'bx; b1 = 1'bx;
      while (c < 100 && lat < 0) begin
         @(posedge clk); #1;
         c++;
         start = 1'b0;
         if (c == 1) b1 = busy;
         if (done) begin lat = c; rd = rdata; er = err; end
         if (noise) begin
            start = c == 1 ? 1'($urandom_range(0, 1)) : 1'b0;
            funct3 = 3'($urandom);
            byte_off = 2'($urandom);
         end
         ram_valid = (c == g1 + 1) || (c == g1 + g2 + 2);
         ram_data = c == g1 + 1 ? hi : lo;
      end
      start = 1'b0; ram_valid = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic run_check(input string nm, input logic [2:0] f3, input logic [1:0] off,
                            input logic [15:0] hi, input logic [15:0] lo, input int g1, input int g2,
                            input logic noise, input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
      int lat;
      logic [31:0] rd;
      logic er, b1;
      do_load(f3, off, hi, lo, g1, g2, noise, lat, rd, er, b1);
      chk({nm, " latency"}, 32'(lat), 32'(exp_lat));
      chk({nm, " rdata"}, rd, exp_rd);
      chk({nm, " err"}, {31'd0, er}, {31'd0, exp_err});
      chk({nm, " busy"}, {31'd0, b1}, {31'd0, exp_lat != 1});
   endtask

   initial begin
      logic [2:0]  f3;
      logic [1:0]  off;
      logic [15:0] hi, lo;
      int          g1, g2, el;
      logic [31:0] er_d;
      logic        ee;
      vecs[0]  = '{3'd2, 2'd0, 16'h1234, 16'hABCD, 0, 0, 32'h1234ABCD, 1'b0, 3};
      vecs[1]  = '{3'd0, 2'd1, 16'h0000, 16'h80FF, 0, 0, 32'hFFFFFF80, 1'b0, 3};
      vecs[2]  = '{3'd4, 2'd1, 16'h0000, 16'h80FF, 0, 0, 32'h00000080, 1'b0, 3};
      vecs[3]  = '{3'd1, 2'd2, 16'h8001, 16'h0000, 0, 0, 32'hFFFF8001, 1'b0, 3};
      vecs[4]  = '{3'd5, 2'd2, 16'h8001, 16'h0000, 0, 0, 32'h00008001, 1'b0, 3};
      vecs[5]  = '{3'd2, 2'd0, 16'h1111, 16'h2222, 10, 0, 32'h0, 1'b1, T + 1};
      vecs[6]  = '{3'd3, 2'd0, 16'h1111, 16'h2222, 0, 0, 32'h0, 1'b1, 1};
      vecs[7]  = '{3'd2, 2'd0, 16'hCAFE, 16'hBEEF, T - 1, T - 1, 32'hCAFEBEEF, 1'b0, 2 * T + 1};
      vecs[8]  = '{3'd2, 2'd0, 16'h3333, 16'h4444, 0, T, 32'h0, 1'b1, T + 2};
      vecs[9]  = '{3'd0, 2'd3, 16'h7F00, 16'h00FF, 1, 2, 32'h0000007F, 1'b0, 6};
`ifdef MISALIGN_TRAP_EN
      vecs[10] = '{3'd2, 2'd2, 16'h1234, 16'hABCD, 0, 0, 32'h0, 1'b1, 1};
      vecs[11] = '{3'd1, 2'd3, 16'h8001, 16'h7FFE, 0, 0, 32'h0, 1'b1, 1};
`else
      vecs[10] = '{3'd2, 2'd2, 16'h1234, 16'hABCD, 0, 0, 32'h1234ABCD, 1'b0, 3};
      vecs[11] = '{3'd1, 2'd3, 16'h8001, 16'h7FFE, 0, 0, 32'hFFFF8001, 1'b0, 3};
`endif
      repeat (3) @(posedge clk);
      #1;
      chk("reset busy", {31'd0, busy}, 32'd0);
      chk("reset done", {31'd0, done}, 32'd0);
      chk("reset err", {31'd0, err}, 32'd0);
      chk("reset rdata", rdata, 32'd0);
      rst_n = 1'b1;
      ram_valid = 1'b1; ram_data = 16'hDEAD;
      repeat (2) @(posedge clk);
      #1;
      ram_valid = 1'b0;
      chk("idle valid ignored", {30'd0, busy, done}, 32'd0);

      for (int i = 0; i < 12; i++)
         run_check($sformatf("vec%0d", i), vecs[i].f3, vecs[i].off, vecs[i].hi, vecs[i].lo,
                   vecs[i].g1, vecs[i].g2, 1'b0, vecs[i].exp_rd, vecs[i].exp_err, vecs[i].exp_lat);

      start = 1'b1; funct3 = 3'd2; byte_off = 2'd0;
      @(posedge clk); #1;
      start = 1'b0; ram_valid = 1'b1; ram_data = 16'h5555;
      @(posedge clk); #1;
      ram_valid = 1'b0;
      chk("pre-reset busy", {31'd0, busy}, 32'd1);
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("midload reset busy", {31'd0, busy}, 32'd0);
      chk("midload reset done", {31'd0, done}, 32'd0);
      ram_valid = 1'b1; ram_data = 16'h6666;
      @(posedge clk); #1;
      chk("midload reset no done", {31'd0, done}, 32'd0);
      chk("midload reset rdata", rdata, 32'd0);
      ram_valid = 1'b0; rst_n = 1'b1;
      @(posedge clk); #1;
      run_check("post-reset LW", 3'd2, 2'd0, 16'h0F0F, 16'hF0F0, 0, 0, 1'b0, 32'h0F0FF0F0, 1'b0, 3);

      for (int i = 0; i < 200; i++) begin
         f3 = 3'($urandom); off = 2'($urandom);
         hi = 16'($urandom); lo = 16'($urandom);
         g1 = $urandom_range(0, 9) < 8 ? $urandom_range(0, 2) : $urandom_range(0, T + 1);
         g2 = $urandom_range(0, 9) < 8 ? $urandom_range(0, 2) : $urandom_range(0, T + 1);
         if (!legal(f3) || misaligned(f3, off)) begin el = 1; er_d = 0; ee = 1'b1; end
         else if (g1 >= T) begin el = T + 1; er_d = 0; ee = 1'b1; end
         else if (g2 >= T) begin el = g1 + 2 + T; er_d = 0; ee = 1'b1; end
         else begin el = g1 + g2 + 3; er_d = model_ext({hi, lo}, f3, off); ee = 1'b0; end
         run_check($sformatf("rand%0d f3=%0d off=%0d", i, f3, off), f3, off, hi, lo, g1, g2, 1'b1, er_d, ee, el);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
